// File: rtl/nibble_serial_cla_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Holds the nibble width, the FSM state type and the WIDTH legality check.
package nibble_serial_cla_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // True when w is a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int w);
    return (w >= NIBBLE_W) && (w % NIBBLE_W == 0);
  endfunction

endpackage

// File: rtl/nibble_serial_cla_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// in_valid/in_ready + X,Y,Cin in; out_valid/out_ready + Sum,Cout out.
// NIBBLE_SERIAL_CLA_ADDER_SUB_EN adds the sub select bit.
interface nibble_serial_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef NIBBLE_SERIAL_CLA_ADDER_SUB_EN
  logic             sub;

  modport master (
    output in_valid, X, Y, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );
  modport slave (
    input  in_valid, X, Y, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`else
  modport master (
    output in_valid, X, Y, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );
  modport slave (
    input  in_valid, X, Y, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`endif
endinterface

// File: rtl/nibble_serial_cla_adder_cla.sv
// 4-bit carry-lookahead adder slice (purely combinational).
// Ports: a, b (nibbles), ci (carry in) -> s (nibble sum), co (carry out).
module cla_4bit_adder
  import nibble_serial_cla_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is formed directly from g/p and ci, no ripple.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co     = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (&w_p & ci);

  assign s = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a CLA slice.
// Ports: clk, rst (async, active-high), bus (slave side of the handshake
// interface). NIBBLE_SERIAL_CLA_ADDER_SUB_EN enables subtract via bus.sub.
module nibble_serial_cla_adder
  import nibble_serial_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_cla_adder_if.slave bus
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_sub;

  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
  logic                w_last;
  logic [WIDTH-1:0]    w_y_in;
  logic                w_c_in;
  logic                w_sub_in;

  // Operands shift right each step, so the slice always sees bits [3:0].
  cla_4bit_adder u_cla (
    .a  (r_x[NIBBLE_W-1:0]),
    .b  (r_y[NIBBLE_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_idx == IW'(N - 1));

`ifdef NIBBLE_SERIAL_CLA_ADDER_SUB_EN
  // X - Y - b = X + ~Y + ~b; borrow-out is the inverted carry.
  assign w_sub_in = bus.sub;
`else
  assign w_sub_in = 1'b0;
`endif
  assign w_y_in = w_sub_in ? ~bus.Y : bus.Y;
  assign w_c_in = w_sub_in ? ~bus.Cin : bus.Cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_sub       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_x        <= bus.X;
            r_y        <= w_y_in;
            r_carry    <= w_c_in;
            r_sub      <= w_sub_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_x     <= r_x >> NIBBLE_W;
          r_y     <= r_y >> NIBBLE_W;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
          for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_s;
            end
          end
          if (w_last) begin
            r_cout      <= r_sub ? ~w_co : w_co;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Sum       = r_sum;
  assign bus.Cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder (WIDTH=16).
// Expected results go to a scoreboard queue on accept, popped on out_valid.
module tb_nibble_serial_cla_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_cla_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_cla_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic cin,
                                 input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    return '{sum: r[W-1:0], cout: r[W]};
  endfunction

  task automatic drive_sub(input logic s);
`ifdef NIBBLE_SERIAL_CLA_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: subtract requested without sub build");
`endif
  endtask

  task automatic run_op(input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic cin,
                        input logic s,
                        input int hold,
                        input bit poke);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    bus.Cin = cin;
    drive_sub(s);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(x, y, cin, s));
    check("busy_in_ready", bus.in_ready, 0);
    if (poke) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.X = 16'hAAAA;
      bus.Y = 16'h5555;
      bus.Cin = ~cin;
    end
    for (k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    check("latency", k, N);
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sum", bus.Sum, e.sum);
      check("cout", bus.Cout, e.cout);
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.Sum, e.sum);
        check("hold_cout", bus.Cout, e.cout);
        check("hold_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("release_valid", bus.out_valid, 0);
      check("release_ready", bus.in_ready, 1);
      check("retain_sum", bus.Sum, e.sum);
    end
  endtask

  task automatic reset_mid_run();
    bit seen;
    @(negedge clk);
    bus.X = 16'h1357;
    bus.Y = 16'h2468;
    bus.Cin = 1'b1;
    drive_sub(1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.Sum, 0);
    check("rst_cout", bus.Cout, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_late_pulse", seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rc;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    bus.Cin = 1'b0;
    drive_sub(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("init_in_ready", bus.in_ready, 1);
    check("init_out_valid", bus.out_valid, 0);
    check("init_sum", bus.Sum, 0);
    check("init_cout", bus.Cout, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 5, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1, 1'b1);
    reset_mid_run();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op(rx, ry, rc, 1'b0, 0, 1'b0);
    end
`ifdef NIBBLE_SERIAL_CLA_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0009, 16'h0003, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op(rx, ry, rc, 1'b1, 0, 1'b0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
`endif
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
